// File: rtl/gerador_aleatorio_pkg.sv
// Shared constants and helpers for the gerador_aleatorio pseudo-random source.
// Holds the LFSR length, the feedback tap positions, the default seed and the
// zero-state substitution used on every seed-load path.
package gerador_aleatorio_pkg;

    localparam int LFSR_LEN = 32;

    // Feedback taps for x^32 + x^22 + x^2 + x + 1 (Fibonacci form).
    localparam int TAP_0 = 31;
    localparam int TAP_1 = 21;
    localparam int TAP_2 = 1;
    localparam int TAP_3 = 0;

    localparam logic [LFSR_LEN-1:0] DEFAULT_SEED = 32'h0000_0001;

    // An all-zero LFSR state never leaves zero, so it is replaced by the default seed.
    function automatic logic [LFSR_LEN-1:0] seed_guard(input logic [LFSR_LEN-1:0] s);
        logic [LFSR_LEN-1:0] r;
        if (s == {LFSR_LEN{1'b0}}) begin
            r = DEFAULT_SEED;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/gerador_aleatorio_lfsr32_step.sv
// One combinational step of the 32-bit Fibonacci LFSR: the feedback bit is the
// XOR of the four taps and enters at bit 0 while the state shifts left.
module lfsr32_step
    import gerador_aleatorio_pkg::*;
(
    input  logic [LFSR_LEN-1:0] state_i,
    output logic [LFSR_LEN-1:0] state_o
);

    logic fb_s;

    // Compute the feedback bit and the shifted state.
    always_comb begin
        fb_s    = state_i[TAP_0] ^ state_i[TAP_1] ^ state_i[TAP_2] ^ state_i[TAP_3];
        state_o = {state_i[LFSR_LEN-2:0], fb_s};
    end

endmodule

// File: rtl/gerador_aleatorio.sv
// gerador_aleatorio: free-running pseudo-random source. A 32-bit maximal-length
// LFSR advances WIDTH steps per clock (unrolled through a chain of lfsr32_step
// instances) and the WIDTH freshly generated bits are registered onto data, so
// consecutive outputs never share bits. The first bit produced in a cycle ends
// up in data[WIDTH-1], the last in data[0].
// Optional build macro GERADOR_ALEATORIO_SEED_LOAD_EN adds the seed_load/seed
// inputs for reseeding at run time (data holds during a load cycle).
module gerador_aleatorio
    import gerador_aleatorio_pkg::*;
#(
    parameter int                  WIDTH = 3,
    parameter logic [LFSR_LEN-1:0] SEED  = 32'h0000_0001
) (
    input  logic                clk,
    input  logic                rst,
`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
    input  logic                seed_load,
    input  logic [LFSR_LEN-1:0] seed,
`endif
    output logic [WIDTH-1:0]    data
);

    generate
        if ((WIDTH < 1) || (WIDTH > LFSR_LEN)) begin : g_width_check
            $error("gerador_aleatorio: WIDTH must lie in 1..32");
        end
    endgenerate

    logic [LFSR_LEN-1:0] lfsr_q;
    logic [LFSR_LEN-1:0] lfsr_d;
    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    data_d;
    logic [LFSR_LEN-1:0] chain_s [0:WIDTH];
    logic [LFSR_LEN-1:0] adv_s;

    assign chain_s[0] = lfsr_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            lfsr32_step u_step (
                .state_i (chain_s[gi]),
                .state_o (chain_s[gi+1])
            );
        end
    endgenerate

    // Next state: WIDTH steps ahead, or the default seed if the state is stuck at zero.
    always_comb begin
        adv_s = chain_s[WIDTH];
        if (lfsr_q == {LFSR_LEN{1'b0}}) begin
            adv_s = DEFAULT_SEED;
        end else begin
            adv_s = chain_s[WIDTH];
        end
    end

    // Select between normal generation and a run-time seed load.
    always_comb begin
        lfsr_d = adv_s;
        data_d = adv_s[WIDTH-1:0];
`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
        if (seed_load) begin
            lfsr_d = seed_guard(seed);
            data_d = data_q;
        end else begin
            lfsr_d = adv_s;
            data_d = adv_s[WIDTH-1:0];
        end
`endif
    end

    // State and output registers; synchronous reset restarts the sequence from SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed_guard(SEED);
            data_q <= {WIDTH{1'b0}};
        end else begin
            lfsr_q <= lfsr_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: tb/tb_gerador_aleatorio.sv
// Self-checking bench for gerador_aleatorio. Four instances share clock and
// reset: WIDTH=3/SEED=1, WIDTH=3/SEED=0, WIDTH=1 and WIDTH=32/SEED=DEADBEEF.
// Each is compared cycle by cycle against a bench-side LFSR model, plus
// hand-computed anchor values, a histogram and a mid-stream reset replay.
module tb_gerador_aleatorio;

    logic        clk;
    logic        rst;
    logic [2:0]  data3;
    logic [2:0]  data3z;
    logic [0:0]  data1;
    logic [31:0] data32;
`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
    logic        seed_load;
    logic [31:0] seed;
`endif

    int checks_cnt;
    int fail_cnt;

    // Models: state and expected output per instance.
    logic [31:0] m3, m3z, m1, m32;
    logic [2:0]  e3, e3z;
    logic [0:0]  e1;
    logic [31:0] e32;

    logic [2:0] rec [0:36];
    int         hist [0:7];

    gerador_aleatorio #(.WIDTH(3), .SEED(32'h0000_0001)) dut (
        .clk(clk), .rst(rst),
`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
        .seed_load(seed_load), .seed(seed),
`endif
        .data(data3));

    gerador_aleatorio #(.WIDTH(3), .SEED(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst),
`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
        .seed_load(seed_load), .seed(seed),
`endif
        .data(data3z));

    gerador_aleatorio #(.WIDTH(1), .SEED(32'h0000_0001)) dut_w1 (
        .clk(clk), .rst(rst),
`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
        .seed_load(seed_load), .seed(seed),
`endif
        .data(data1));

    gerador_aleatorio #(.WIDTH(32), .SEED(32'hDEAD_BEEF)) dut_w32 (
        .clk(clk), .rst(rst),
`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
        .seed_load(seed_load), .seed(seed),
`endif
        .data(data32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] guard(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] s, input int w);
        logic [31:0] t;
        logic        fb;
        if (s == 32'd0) return 32'd1;
        t = s;
        for (int k = 0; k < w; k++) begin
            fb = t[31] ^ t[21] ^ t[1] ^ t[0];
            t  = {t[30:0], fb};
        end
        return t;
    endfunction

    // Advance one clock: update every model from the inputs in force at the edge.
    task automatic tick();
        logic ld;
        logic [31:0] sd;
        ld = 1'b0;
        sd = 32'd0;
`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
        ld = seed_load;
        sd = seed;
`endif
        @(posedge clk);
        if (rst) begin
            m3 = 32'd1; m3z = 32'd1; m1 = 32'd1; m32 = 32'hDEAD_BEEF;
            e3 = 3'd0; e3z = 3'd0; e1 = 1'b0; e32 = 32'd0;
        end else if (ld) begin
            m3 = guard(sd); m3z = guard(sd); m1 = guard(sd); m32 = guard(sd);
        end else begin
            m3  = adv(m3, 3);   e3  = m3[2:0];
            m3z = adv(m3z, 3);  e3z = m3z[2:0];
            m1  = adv(m1, 1);   e1  = m1[0:0];
            m32 = adv(m32, 32); e32 = m32;
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_d3"},   {61'd0, data3}, {61'd0, e3});
        check_eq({tag, "_s3"},   {32'd0, dut.lfsr_q}, {32'd0, m3});
        check_eq({tag, "_d3z"},  {61'd0, data3z}, {61'd0, e3z});
        check_eq({tag, "_s3z"},  {32'd0, dut0.lfsr_q}, {32'd0, m3z});
        check_eq({tag, "_d1"},   {63'd0, data1}, {63'd0, e1});
        check_eq({tag, "_d32"},  {32'd0, data32}, {32'd0, e32});
        check_eq({tag, "_s32"},  {32'd0, dut_w32.lfsr_q}, {32'd0, m32});
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        for (int b = 0; b < 8; b++) hist[b] = 0;
        m3 = 32'd0; m3z = 32'd0; m1 = 32'd0; m32 = 32'd0;
        e3 = 3'd0; e3z = 3'd0; e1 = 1'b0; e32 = 32'd0;
        rst = 1'b1;
`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
        seed_load = 1'b0;
        seed      = 32'd0;
`endif
        @(negedge clk);

        // Reset held for two cycles.
        tick();
        tick();
        check_eq("rst_data",  {61'd0, data3}, 64'd0);
        check_eq("rst_lfsr",  {32'd0, dut.lfsr_q}, 64'h1);
        check_eq("rst_lfsr0", {32'd0, dut0.lfsr_q}, 64'h1);
        check_eq("rst_lfsr32", {32'd0, dut_w32.lfsr_q}, 64'hDEAD_BEEF);
        check_all("rst");

        // Release: hand-computed first two values.
        rst = 1'b0;
        tick();
        check_eq("first_data", {61'd0, data3}, 64'd5);
        check_eq("first_lfsr", {32'd0, dut.lfsr_q}, 64'h0000_000D);
        rec[0] = data3;
        check_all("c1");
        tick();
        check_eq("second_data", {61'd0, data3}, 64'd5);
        check_eq("second_lfsr", {32'd0, dut.lfsr_q}, 64'h0000_006D);
        rec[1] = data3;
        check_all("c2");
        for (int i = 2; i < 37; i++) begin
            tick();
            rec[i] = data3;
            check_all("pre");
        end

        // Mid-stream reset for one cycle, then replay.
        rst = 1'b1;
        tick();
        check_eq("mid_rst_data", {61'd0, data3}, 64'd0);
        check_eq("mid_rst_lfsr", {32'd0, dut.lfsr_q}, 64'h1);
        rst = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick();
            check_eq("replay", {61'd0, data3}, {61'd0, rec[i]});
            check_all("post");
        end

        // Long run against the model, histogram over the first 1600 values.
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (i < 1600) hist[data3] = hist[data3] + 1;
            check_all("long");
            check_eq("lfsr0_nz", {63'd0, (dut0.lfsr_q != 32'd0)}, 64'd1);
        end
        for (int b = 0; b < 8; b++) begin
            check_eq("hist_bin", {63'd0, (hist[b] >= 150 && hist[b] <= 250)}, 64'd1);
        end

`ifdef GERADOR_ALEATORIO_SEED_LOAD_EN
        // Reseed with 1: data holds, then 5, 5.
        seed_load = 1'b1;
        seed      = 32'h0000_0001;
        tick();
        check_eq("load_hold", {61'd0, data3}, {61'd0, e3});
        check_eq("load_lfsr", {32'd0, dut.lfsr_q}, 64'h1);
        seed_load = 1'b0;
        tick();
        check_eq("load_v1", {61'd0, data3}, 64'd5);
        tick();
        check_eq("load_v2", {61'd0, data3}, 64'd5);
        check_all("ld");

        // Zero seed is treated as 1.
        seed_load = 1'b1;
        seed      = 32'h0000_0000;
        tick();
        check_eq("load0_lfsr", {32'd0, dut.lfsr_q}, 64'h1);
        seed_load = 1'b0;
        tick();
        check_eq("load0_v1", {61'd0, data3}, 64'd5);
        check_eq("load0_s1", {32'd0, dut.lfsr_q}, 64'h0000_000D);

        // Reset wins over a simultaneous seed load.
        rst       = 1'b1;
        seed_load = 1'b1;
        seed      = 32'h0000_ABCD;
        tick();
        check_eq("prio_data", {61'd0, data3}, 64'd0);
        check_eq("prio_lfsr", {32'd0, dut.lfsr_q}, 64'h1);
        rst       = 1'b0;
        seed_load = 1'b0;
        tick();
        check_eq("prio_v1", {61'd0, data3}, 64'd5);
        check_all("prio");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/gerador_aleatorio.md
# gerador_aleatorio

Pseudo-random number source built on a 32-bit maximal-length LFSR. Every clock cycle it produces a fresh, non-overlapping `WIDTH`-bit value. It is a free-running utility block feeding game logic that needs random choices, such as event selection and image/animation variation. It has no handshake: `data` is valid on every cycle after reset.

## Interface
Parameters:
- `WIDTH`, default 3: output width in bits; legal range 1..32.
- `SEED`, default 32'h0000_0001: LFSR state loaded on reset; a value of 0 is replaced by 32'h0000_0001.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1: system clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `data`  output  WIDTH: current random value, registered.

## Operation
- State: 32-bit register `lfsr`, Fibonacci form, polynomial x^32+x^22+x^2+x+1 (maximal period 2^32−1).
- One LFSR step:
  - fb = s[31] ^ s[21] ^ s[1] ^ s[0].
  - s_next = {s[30:0], fb}.
- Per cycle, the LFSR advances exactly `WIDTH` steps. These steps are unrolled combinationally in one cycle.
- Output mapping:
  - `data` <= low `WIDTH` bits of the advanced state.
  - The first bit generated in the cycle lands in `data[WIDTH-1]`; the last lands in `data[0]`.
  - Successive outputs therefore never share bits.
- Lock-up guard: if the state register is ever all-zero, the next state is 32'h0000_0001 rather than the shifted value, and `data` is updated normally from it. A zero state is unreachable from a legal seed; the guard exists for the seed-load path and for SEU robustness.
- No enable input: the generator runs every cycle.

## Timing
- Reset (`rst`=1 at a rising edge):
  - `lfsr` <= SEED, with 0 mapped to 1.
  - `data` <= 0.
  - Reset dominates any other activity.
- First valid `data` appears on the first rising edge with `rst`=0, i.e. one cycle of latency.
- Reset asserted mid-stream restarts the identical sequence from SEED. The sequence is deterministic and repeatable.
- Throughput: one new value per clock.
- The output is a register; there is no combinational path from inputs to `data`.

## Configuration
- Macro `GERADOR_ALEATORIO_SEED_LOAD_EN`.
- When defined, the block adds two inputs: `seed_load` (1 bit) and `seed` (32 bits). A cycle with `seed_load`=1 and `rst`=0 does the following:
  - `lfsr` <= `seed`, with 0 mapped to 1.
  - `data` holds its previous value.
  - Generation resumes from the new seed on the next cycle.
  - `rst` has priority over `seed_load`.
- When not defined, neither port exists and the state can only be seeded by `SEED` at reset.

## Structure
- Package `gerador_aleatorio_pkg` contains:
  - `LFSR_LEN` = 32.
  - Tap positions (31, 21, 1, 0).
  - `DEFAULT_SEED` = 32'h0000_0001.
  - A function applying the zero-state substitution.
- Sub-module `lfsr32_step`: purely combinational, 32-bit state in, stepped 32-bit state out. It is instantiated `WIDTH` times in a generate chain inside `gerador_aleatorio`.
- Elaboration-time assertion: `WIDTH` must lie in 1..32.

## Test plan
- Reset value: with SEED=1, assert `rst` for 2 cycles → `data`==0 and `lfsr`==32'h0000_0001 while in reset.
- Known sequence: WIDTH=3, SEED=1, release reset → first `data`=3'd5 with `lfsr`=32'h0000_000D; second `data`=3'd5 with `lfsr`=32'h0000_006D. Continue against a bit-exact reference model for 10,000 cycles with zero mismatches.
- Distribution: WIDTH=3, run 1,600 cycles and histogram `data` → every one of the 8 bins holds between 150 and 250 hits, and no bin is empty.
- Mid-stream reset: run 37 cycles, assert `rst` for one cycle, release → the output sequence repeats cycle-for-cycle from the first value (5, 5, …).
- Zero seed: build with SEED=0 → behaviour is identical to SEED=1, and `lfsr` is never 0 over 10,000 cycles.
- With `GERADOR_ALEATORIO_SEED_LOAD_EN` defined:
  - Pulse `seed_load` with `seed`=32'h0000_0001 mid-run → `data` holds for that cycle, then 5, 5 follow.
  - `seed`=0 → treated as 1.
  - `seed_load` together with `rst` → reset wins.
